cla_adder_pipe: RTL
===================

Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Successor to the fixed 4-bit registered CLA: WIDTH-bit operands built from 4-bit lookahead groups, with the ripple between groups broken by pipeline registers.
- Valid/ready handshake on input and output; per-transaction add/subtract select; signed overflow flag.
- Sits between operand producers and result consumers in the datapath.

Parameters:
- WIDTH, 16: operand/result width; must be a multiple of 4 (4..64).
- GROUPS_PER_STAGE, 1: number of 4-bit CLA groups evaluated per pipeline stage; (WIDTH/4) must be divisible by it.
- L (derived, localparam): pipeline depth = WIDTH/(4*GROUPS_PER_STAGE).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in (add mode only).
- sub  in  1  0 = A+B+cin; 1 = A-B (B inverted, carry in forced 1, cin ignored).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (sub mode: 1 = no borrow).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync deassert): all stage valid bits = 0, all data registers = 0; outputs out_valid = 0, sum = 0, cout = 0, ovf = 0. Reset mid-operation discards all in-flight transactions; no partial results appear after release.
- Within a group: generate g = a&b', propagate p = a^b' (b' = b ^ {WIDTH{sub}}); 4-bit lookahead carries c1..c4 computed in parallel from g, p and the group carry-in; no ripple inside a group.
- Stage i (0..L-1) evaluates groups i*GPS..(i+1)*GPS-1 using the registered carry from stage i-1 (stage 0 uses the effective carry in). Results are registered at the end of the stage.
- Already-computed low sum bits are skew-delayed; not-yet-processed operand bits are forwarded through registers alongside each stage.
- Global advance = !out_valid || out_ready.
  - On advance, every stage shifts one position, carrying its valid bit; bubbles propagate as valid = 0.
  - Without advance, all stages hold.
- in_ready = advance. The combinational path out_ready -> in_ready is permitted.
- A transaction is accepted at a rising edge where in_valid && in_ready. Accepted at edge k with no stalls: outputs valid after edge k+L-1; earliest output handshake is at edge k+L.
- Throughput: one transaction per cycle when out_ready stays high. Order is preserved; no drop or duplication under any stall pattern.
- Outputs hold stable while out_valid && !out_ready.
- in_valid with in_ready low: no acceptance; the producer must hold its inputs.
- Wrap-around: sum is modulo 2^WIDTH. Overflow/carry are reported only via ovf/cout, never by truncation side effects.

Optional Feature:
- Macro: CLA_ADDER_SAT_EN.
- Defined: on signed overflow, sum saturates:
  - 2^(WIDTH-1)-1 if the effective operands were both non-negative;
  - -2^(WIDTH-1) if both negative.
  - ovf and cout are still reported unchanged. Saturation is applied in the last stage; latency is unchanged.
- Undefined: sum is the wrapped result; no saturation logic is present.

Test Plan (WIDTH=16, GROUPS_PER_STAGE=1, L=4, out_ready=1 unless stated):
- Reset: hold reset_n=0 for 3 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0 throughout; nothing emerges after release.
- Latency: accept a=0x0003, b=0x0005, cin=0, sub=0 at edge k -> out_valid after edge k+3, sum=0x0008, cout=0, ovf=0.
- Full carry chain / wrap: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Then sub with a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1 (with CLA_ADDER_SAT_EN: sum=0x8000).
- Back-to-back streaming: 32 random transactions, one per cycle -> 32 results in order, one per cycle, each matching the reference model.
- Backpressure: stream 10 transactions while toggling out_ready with a random pattern -> sum stable while stalled, in_ready == advance, no loss or duplication, order preserved.
- Reset mid-flight: assert reset_n=0 with 3 transactions in flight -> out_valid drops asynchronously; after release, only newly accepted transactions appear.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups,
// one or more groups per stage, valid/ready handshake. Optional saturation: CLA_ADDER_SAT_EN.
module cla_adder_pipe #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int GPS = GROUPS_PER_STAGE;
    localparam int SW  = 4 * GPS;
    localparam int L   = WIDTH / SW;

    // Returns {c4, c3, s[3:0]}; all carries derived in parallel from g/p and c0.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1, c2, c3, c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, c3, p ^ {c3, c2, c1, c0}};
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar gi = 0; gi < L; gi++) begin : g_stg
        logic [WIDTH-1:0] a_st, b_st, s_st;
        logic             c_st, v_st;
        logic [WIDTH-1:0] s_d, fin_d;
        logic             c_d, cm_d, ovf_d;
        logic [5:0]       grp;
        logic             v_q, c_q, ovf_q;
        logic [WIDTH-1:0] a_q, b_q, s_q;

        // Stage 0 works on the effective operands; later stages on forwarded ones.
        if (gi == 0) begin : g_src
            assign a_st = a;
            assign b_st = b ^ {WIDTH{sub}};
            assign c_st = sub | cin;
            assign s_st = '0;
            assign v_st = in_valid;
        end else begin : g_src
            assign a_st = g_stg[gi-1].a_q;
            assign b_st = g_stg[gi-1].b_q;
            assign c_st = g_stg[gi-1].c_q;
            assign s_st = g_stg[gi-1].s_q;
            assign v_st = g_stg[gi-1].v_q;
        end

        always_comb begin
            s_d  = s_st;
            c_d  = c_st;
            cm_d = 1'b0;
            grp  = '0;
            for (int g = 0; g < GPS; g++) begin
                grp = cla4(a_st[gi*SW + 4*g +: 4], b_st[gi*SW + 4*g +: 4], c_d);
                s_d[gi*SW + 4*g +: 4] = grp[3:0];
                cm_d = grp[4];
                c_d  = grp[5];
            end
        end

        if (gi == L - 1) begin : g_fin
            always_comb begin
                ovf_d = cm_d ^ c_d;
                fin_d = s_d;
`ifdef CLA_ADDER_SAT_EN
                // On overflow both effective operands share a sign; clamp toward it.
                if (ovf_d)
                    fin_d = a_st[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
        end else begin : g_mid
            assign ovf_d = 1'b0;
            assign fin_d = s_d;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q   <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                c_q   <= 1'b0;
                ovf_q <= 1'b0;
            end else if (advance) begin
                v_q   <= v_st;
                a_q   <= a_st;
                b_q   <= b_st;
                s_q   <= fin_d;
                c_q   <= c_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = g_stg[L-1].v_q;
    assign sum       = g_stg[L-1].s_q;
    assign cout      = g_stg[L-1].c_q;
    assign ovf       = g_stg[L-1].ovf_q;

endmodule
